// File: rtl/disp_scan_pkg.sv
// Shared 7-segment display definitions: segment type, hex glyph table and decode helper.
// Segments are active-low, bit 0 = a ... bit 6 = g.
package disp_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  localparam seg_t SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic seg_t hex_to_seg(input logic [3:0] i_hex);
    return SEG_HEX[i_hex];
  endfunction

endpackage

// File: rtl/disp_scan_if.sv
// Digit-buffer inputs and multiplexed display outputs of the scan driver.
interface disp_scan_if import disp_pkg::*; #(
  parameter int N_DIGITS = 8
);

  localparam int IDX_W = $clog2(N_DIGITS);

  logic [4*N_DIGITS-1:0] data_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   blank_in;
  logic [3:0]            bright;
  logic [N_DIGITS-1:0]   an;
  seg_t                  seg;
  logic                  dp;
  logic                  frame_start;
  logic [IDX_W-1:0]      cur_digit;

  modport master (
    output data_in, dp_in, blank_in, bright,
    input  an, seg, dp, frame_start, cur_digit
  );

  modport slave (
    input  data_in, dp_in, blank_in, bright,
    output an, seg, dp, frame_start, cur_digit
  );

endinterface

// File: rtl/disp_scan_seg_decoder.sv
// Combinational hex-to-segment decoder shared by all scanned digits.
module seg_decoder import disp_pkg::*; (
  input  logic [3:0] i_hex,
  output seg_t       o_seg
);

  assign o_seg = hex_to_seg(i_hex);

endmodule

// File: rtl/disp_scan.sv
// Time-multiplexed N-digit common-anode 7-segment driver with frame snapshot,
// ghost blanking at each slot start and 16-level brightness PWM.
module disp_scan import disp_pkg::*; #(
  parameter int N_DIGITS  = 8,
  parameter int TICK_DIV  = 6250,
  parameter int BLANK_CYC = 64
) (
  input logic        clock,
  input logic        reset,
  disp_scan_if.slave bus
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [4*N_DIGITS-1:0] r_sh_data;
  logic [N_DIGITS-1:0]   r_sh_dp;
  logic [N_DIGITS-1:0]   r_sh_blank;
  logic [N_DIGITS-1:0]   r_an;
  seg_t                  r_seg;
  logic                  r_dp;

  logic                  w_cnt_wrap;
  logic                  w_frame_pt;
  logic                  w_pwm_on;
  logic                  w_an_en;
  logic                  w_blank;
  logic [3:0]            w_hex;
  seg_t                  w_seg_dec;
  logic [N_DIGITS-1:0]   w_an_nxt;
  seg_t                  w_seg_nxt;
  logic                  w_dp_nxt;

  assign w_cnt_wrap = (r_cnt == CNT_LAST);
  assign w_frame_pt = (r_cnt == {CNT_W{1'b0}}) && (r_idx == {IDX_W{1'b0}});
  assign w_hex      = r_sh_data[{r_idx, 2'b00} +: 4];
  assign w_blank    = r_sh_blank[r_idx];
  assign w_pwm_on   = (bus.bright == 4'hF) || (r_cnt[3:0] < bus.bright);
  assign w_an_en    = (r_cnt >= CNT_BLANK) && !w_blank && w_pwm_on;

  seg_decoder u_seg_decoder (
    .i_hex (w_hex),
    .o_seg (w_seg_dec)
  );

  // Slot prescaler: counts cycles within one digit slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_cnt_wrap) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Slot index: advances once per prescaler wrap, wrapping after the last digit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idx <= {IDX_W{1'b0}};
    end else if (w_cnt_wrap) begin
      r_idx <= (r_idx == IDX_LAST) ? {IDX_W{1'b0}} : r_idx + IDX_W'(1);
    end else begin
      r_idx <= r_idx;
    end
  end

  // Frame snapshot: the whole frame is drawn from one consistent copy of the buffer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sh_data  <= {(4*N_DIGITS){1'b0}};
      r_sh_dp    <= {N_DIGITS{1'b0}};
      r_sh_blank <= {N_DIGITS{1'b0}};
    end else if (w_frame_pt) begin
      r_sh_data  <= bus.data_in;
      r_sh_dp    <= bus.dp_in;
      r_sh_blank <= bus.blank_in;
    end else begin
      r_sh_data  <= r_sh_data;
      r_sh_dp    <= r_sh_dp;
      r_sh_blank <= r_sh_blank;
    end
  end

  // Next output values; seg only moves with idx/shadow, both of which change inside the blank window.
  always_comb begin
    w_an_nxt  = {N_DIGITS{1'b1}};
    w_seg_nxt = SEG_OFF;
    w_dp_nxt  = 1'b1;
    if (w_an_en) begin
      w_an_nxt = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << r_idx);
    end else begin
      w_an_nxt = {N_DIGITS{1'b1}};
    end
    if (w_blank) begin
      w_seg_nxt = SEG_OFF;
    end else begin
      w_seg_nxt = w_seg_dec;
    end
    w_dp_nxt = !(w_an_en && r_sh_dp[r_idx]);
  end

  // Output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_an  <= {N_DIGITS{1'b1}};
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  assign bus.an          = r_an;
  assign bus.seg         = r_seg;
  assign bus.dp          = r_dp;
  assign bus.cur_digit   = r_idx;
  // Gated by reset so the frame marker stays low while the block is held in reset.
  assign bus.frame_start = reset && w_frame_pt;

endmodule

// File: tb/tb_disp_scan.sv
// Scoreboard bench for disp_scan: a cycle-position reference model predicts every output
// cycle, and a negedge monitor compares each prediction once its clock edge has occurred.
module tb_disp_scan;

  localparam int N     = 8;
  localparam int TD    = 32;
  localparam int BC    = 4;
  localparam int FRAME = N * TD;

  typedef struct packed {
    logic [31:0] due;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        fs;
    logic [2:0]  cur;
  } exp_t;

  logic clock;
  logic reset;
  int   edge_cnt = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t expq[$];

  // Reference model state: position since reset release and the frame copy on display.
  int          p = 0;
  logic [31:0] sh_data  = 32'h0;
  logic [7:0]  sh_dp    = 8'h0;
  logic [7:0]  sh_blank = 8'h0;

  // Lit-segment patterns (1 = lit, gfedcba) for 0-9, A, b, C, d, E, F.
  logic [6:0] lit_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  disp_scan_if #(.N_DIGITS(N)) bus ();

  disp_scan #(.N_DIGITS(N), .TICK_DIV(TD), .BLANK_CYC(BC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  // Predict the outputs produced from the current position, then advance one cycle.
  task automatic step();
    exp_t       e;
    int         slot;
    int         c;
    logic       vis;
    logic [3:0] nib;
    slot  = (p / TD) % N;
    c     = p % TD;
    nib   = sh_data[slot*4 +: 4];
    vis   = (c >= BC) && !sh_blank[slot] &&
            ((bus.bright == 4'd15) || ((c % 16) < int'(bus.bright)));
    e.due = 32'(edge_cnt + 1);
    e.an  = vis ? ~(8'h01 << slot) : 8'hFF;
    e.seg = sh_blank[slot] ? 7'h7F : ~lit_tab[nib];
    e.dp  = !(vis && sh_dp[slot]);
    e.fs  = (((p + 1) % FRAME) == 0);
    e.cur = 3'(((p + 1) / TD) % N);
    expq.push_back(e);
    if ((p % FRAME) == 0) begin
      sh_data  = bus.data_in;
      sh_dp    = bus.dp_in;
      sh_blank = bus.blank_in;
    end
    p++;
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_an"},  32'(bus.an),          32'hFF);
    chk({tag, "_seg"}, 32'(bus.seg),         32'h7F);
    chk({tag, "_dp"},  32'(bus.dp),          32'h1);
    chk({tag, "_cur"}, 32'(bus.cur_digit),   32'h0);
    chk({tag, "_fs"},  32'(bus.frame_start), 32'h0);
  endtask

  task automatic release_reset();
    reset    = 1'b1;
    p        = 0;
    sh_data  = 32'h0;
    sh_dp    = 8'h0;
    sh_blank = 8'h0;
    #1;
    chk("rel_fs",  32'(bus.frame_start), 32'h1);
    chk("rel_cur", 32'(bus.cur_digit),   32'h0);
  endtask

  task automatic random_tweak();
    if ($urandom_range(0, 31) == 0) bus.data_in  = $urandom();
    if ($urandom_range(0, 31) == 0) bus.dp_in    = 8'($urandom());
    if ($urandom_range(0, 31) == 0) bus.blank_in = 8'($urandom());
    if ($urandom_range(0, 31) == 0) bus.bright   = 4'($urandom_range(0, 15));
  endtask

  // Monitor: compare every prediction whose clock edge has passed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (expq.size() > 0 && int'(expq[0].due) <= edge_cnt) begin
        e = expq.pop_front();
        n_vec++;
        if ({bus.an, bus.seg, bus.dp, bus.frame_start, bus.cur_digit} !==
            {e.an, e.seg, e.dp, e.fs, e.cur}) begin
          n_err++;
          $display("FAIL scan@edge%0d: an=%h/%h seg=%h/%h dp=%b/%b fs=%b/%b cur=%0d/%0d (got/expected)",
                   e.due, bus.an, e.an, bus.seg, e.seg, bus.dp, e.dp,
                   bus.frame_start, e.fs, bus.cur_digit, e.cur);
        end
      end
    end
  end

  initial begin
    reset        = 1'b1;
    bus.data_in  = 32'h0;
    bus.dp_in    = 8'h0;
    bus.blank_in = 8'h0;
    bus.bright   = 4'hF;
    #1;
    reset        = 1'b0;
    bus.data_in  = $urandom();
    bus.dp_in    = 8'($urandom());
    bus.blank_in = 8'($urandom());
    bus.bright   = 4'($urandom_range(0, 15));
    #1;
    check_reset_state("por");
    repeat (3) @(posedge clock);
    #1;

    // Plain scan of 0..7 at full brightness.
    bus.data_in  = 32'h76543210;
    bus.dp_in    = 8'h00;
    bus.blank_in = 8'h00;
    bus.bright   = 4'hF;
    release_reset();
    for (int i = 0; i < 2*FRAME; i++) step();

    // Mid-frame buffer change must wait for the next frame.
    for (int i = 0; i < 2*FRAME; i++) begin
      if ((p % FRAME) == 3*TD + 10) bus.data_in = 32'hFFFFFFFF;
      step();
    end

    // Brightness off, then half duty.
    bus.data_in = 32'h76543210;
    bus.bright  = 4'h0;
    for (int i = 0; i < FRAME; i++) step();
    bus.bright  = 4'h8;
    for (int i = 0; i < FRAME; i++) step();

    // Blanked digit 0 and decimal point on digit 7.
    bus.bright   = 4'hF;
    bus.blank_in = 8'h01;
    bus.dp_in    = 8'h80;
    for (int i = 0; i < 2*FRAME; i++) step();

    // Random buffer, dp, blank and brightness traffic.
    for (int i = 0; i < 4*FRAME; i++) begin
      random_tweak();
      step();
    end

    // Reset in the middle of slot 5.
    for (int i = 0; i < FRAME; i++) begin
      if (((p / TD) % N) == 5 && (p % TD) == 12) break;
      random_tweak();
      step();
    end
    chk("pre_rst_cur", 32'(bus.cur_digit), 32'h5);
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    check_reset_state("mid");
    @(posedge clock);
    #1;
    bus.data_in = $urandom();
    bus.dp_in   = 8'($urandom());
    release_reset();
    for (int i = 0; i < 2*FRAME; i++) begin
      random_tweak();
      step();
    end

    repeat (3) @(negedge clock);
    #1;
    chk("drain", 32'(expq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
